// File: rtl/id_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_issue_ctrl_pkg
// Description : Shared widths and holding-register state encodings for the
//               ID issue controller and its scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package id_issue_ctrl_pkg;

  // Default widths: XLEN-bit instructions/PCs, 32 architectural registers
  localparam int XLEN_DEF     = 32;
  localparam int REG_AW_DEF   = 5;
  localparam int STALL_CW_DEF = 16;

  // Only "empty" vs "held" is registered. READY/STALL are derived every cycle
  // from the hazard term, so they never need a state encoding of their own.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HELD  = 1'b1;

endpackage : id_issue_ctrl_pkg
`default_nettype wire

// File: rtl/id_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : id_scoreboard
// Description : Busy-register scoreboard with writeback clear, issue set and
//               a three-port effective-busy lookup (writeback bypassed).
// Revision    : 1.0 - initial release
// ============================================================================
module id_scoreboard
  import id_issue_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wb_valid_i,
  input  logic [REG_AW-1:0]      wb_rd_i,
  input  logic                   set_i,
  input  logic [REG_AW-1:0]      set_rd_i,
  input  logic [REG_AW-1:0]      rs1_i,
  input  logic [REG_AW-1:0]      rs2_i,
  input  logic [REG_AW-1:0]      rd_i,
  output logic                   eb_rs1_o,
  output logic                   eb_rs2_o,
  output logic                   eb_rd_o,
  output logic [(1<<REG_AW)-1:0] busy_o
);

  logic [(1<<REG_AW)-1:0] busy_q;
  logic [(1<<REG_AW)-1:0] busy_d;
  logic [(1<<REG_AW)-1:0] w_eb;

  // A register being written back this cycle is already readable because the
  // register file is write-through, so it no longer counts as busy.
  for (genvar r = 0; r < (1 << REG_AW); r++) begin : g_eb
    assign w_eb[r] = busy_q[r] && !(wb_valid_i && (wb_rd_i == REG_AW'(r)));
  end

  assign eb_rs1_o = w_eb[rs1_i];
  assign eb_rs2_o = w_eb[rs2_i];
  assign eb_rd_o  = w_eb[rd_i];
  assign busy_o   = busy_q;

  // Next busy vector: clear on writeback, then set on issue so a same-register
  // collision leaves the newer producer marked busy; x0 is never busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i) begin
      busy_d[wb_rd_i] = 1'b0;
    end
    if (set_i) begin
      busy_d[set_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule : id_scoreboard
`default_nettype wire

// File: rtl/id_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : id_issue_ctrl
// Description : ID-stage issue controller. Holds one fetched instruction,
//               checks decoder register usage against the busy scoreboard,
//               issues with valid/ready, and supports pipeline flush.
// Revision    : 1.0 - initial release
// ============================================================================
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int STALL_CW = STALL_CW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_valid,
  input  logic [XLEN-1:0]        if_instr,
  input  logic [XLEN-1:0]        if_pc,
  output logic                   if_ready,
  output logic [XLEN-1:0]        id_instr,
  output logic [XLEN-1:0]        id_pc,
  input  logic                   dec_rs1_en,
  input  logic [REG_AW-1:0]      dec_rs1,
  input  logic                   dec_rs2_en,
  input  logic [REG_AW-1:0]      dec_rs2,
  input  logic                   dec_rd_en,
  input  logic [REG_AW-1:0]      dec_rd,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  input  logic                   wb_valid,
  input  logic [REG_AW-1:0]      wb_rd,
  input  logic                   flush,
  output logic [(1<<REG_AW)-1:0] busy_vec,
  output logic [STALL_CW-1:0]    stall_cnt
);

  logic [0:0]          state_q, state_d;
  logic [XLEN-1:0]     instr_q, instr_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [STALL_CW-1:0] stall_q, stall_d;

  logic w_id_valid;
  logic w_use1, w_use2, w_wr;
  logic w_eb_rs1, w_eb_rs2, w_eb_rd;
  logic w_hazard;
  logic w_issue;
  logic w_accept;

  assign w_id_valid = (state_q == ST_HELD);

  // x0 is hard-wired zero, so reading or writing it never creates a dependency
  assign w_use1 = dec_rs1_en && (dec_rs1 != '0);
  assign w_use2 = dec_rs2_en && (dec_rs2 != '0);
  assign w_wr   = dec_rd_en  && (dec_rd  != '0);

  id_scoreboard #(
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid_i (wb_valid),
    .wb_rd_i    (wb_rd),
    .set_i      (w_issue && w_wr),
    .set_rd_i   (dec_rd),
    .rs1_i      (dec_rs1),
    .rs2_i      (dec_rs2),
    .rd_i       (dec_rd),
    .eb_rs1_o   (w_eb_rs1),
    .eb_rs2_o   (w_eb_rs2),
    .eb_rd_o    (w_eb_rd),
    .busy_o     (busy_vec)
  );

  // RAW on either source, or WAW on the destination
  assign w_hazard = (w_use1 && w_eb_rs1) || (w_use2 && w_eb_rs2) || (w_wr && w_eb_rd);

  // Flush dominates: nothing issues and nothing is accepted in that cycle.
  // Accepting while issuing gives zero-bubble back-to-back throughput.
  assign ex_valid = w_id_valid && !w_hazard && !flush;
  assign w_issue  = ex_valid && ex_ready;
  assign if_ready = !flush && (!w_id_valid || w_issue);
  assign w_accept = if_valid && if_ready;

  assign id_instr  = instr_q;
  assign id_pc     = pc_q;
  assign stall_cnt = stall_q;

  // Holding-register next state; the scoreboard is left alone on flush
  // because already-issued instructions will still write back.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (w_accept) begin
      state_d = ST_HELD;
      instr_d = if_instr;
      pc_d    = if_pc;
    end else if (w_issue) begin
      state_d = ST_EMPTY;
    end
  end

  // Saturating count of cycles a held instruction waits on a hazard
  always_comb begin
    stall_d = stall_q;
    if (w_id_valid && w_hazard && !flush && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CW'(1);
    end
  end

  // Holding register and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      instr_q <= '0;
      pc_q    <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      stall_q <= stall_d;
    end
  end

endmodule : id_issue_ctrl
`default_nettype wire
